seq_div_ctrl: RTL and testbench
===============================

Name: seq_div_ctrl

Overview:
Iterative restoring-division controller. It time-multiplexes a single (WIDTH+1)-bit row of full-subtractor/mux cells over WIDTH cycles to produce quotient and remainder, instead of using a full array divider. The block owns the FSM, the partial-remainder and quotient shift registers, and the row's Ctrl (restore) signal. It sits between the operand-issue logic and result consumers, behind a start/done handshake.

Parameters:
WIDTH, 8, operand/quotient/remainder bit width (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, captured when start accepted
divisor  input  WIDTH  unsigned divisor, captured when start accepted
busy  output  1  high while iterating
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  unsigned quotient, held until next accepted start
remainder  output  WIDTH  unsigned remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor==0; cleared on next accepted start

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter/registers=0. No done pulse for an aborted operation.
- FSM states: IDLE, CALC, DONE.
- IDLE or DONE with start=1 at edge E0 (accepted):
  - Capture operands; clear div_by_zero.
  - If divisor!=0: go to CALC, busy=1, R=0, Q=dividend, count=0.
  - If divisor==0: go to DONE directly; quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
- DONE with start=0: go to IDLE. done=1 only while in DONE (exactly one cycle unless restarted). Start in DONE is accepted (back-to-back ops).
- CALC iteration, one per edge:
  - A = {R, Q[WIDTH-1]} (WIDTH+1 bits); B = {1'b0, divisor}.
  - Ripple subtract through the cell row with Bin(lsb)=0; Ctrl = final borrow-out.
  - Ctrl=1 (negative): cell outputs select A (restore), quotient bit=0.
  - Ctrl=0: cell outputs select the difference, quotient bit=1.
  - R <= row output [WIDTH-1:0]; Q <= {Q[WIDTH-2:0], quotient bit}; count++.
  - All arithmetic unsigned, WIDTH+1 internal bits; no overflow possible since R<divisor invariant.
- On the iteration edge where count reaches WIDTH-1 (the WIDTH-th iteration): go to DONE. quotient<=Q, remainder<=R (final values), busy<=0.
- Latency: divisor!=0: done high after the WIDTH-th edge following E0. Divisor==0: done high after E0 itself (1 cycle).
- start while busy=1: ignored, no effect on operands or state.
- Operand inputs may change freely after acceptance.
- quotient/remainder change only on completion or reset; stable between done and next completion.

Test Plan:
- WIDTH=8, start with 100/7 → busy for 8 cycles; done pulses 8 edges after start edge; quotient=14, remainder=2, div_by_zero=0.
- 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 255/255 → 1, 0.
- 200/0 → done 1 cycle after start; quotient=255, remainder=200, div_by_zero=1, busy never high. Next start 9/3 → div_by_zero=0, quotient=3, remainder=0.
- Start 100/7, then start=1 with 50/5 at iteration 3 → ignored; result 14/2. Assert start 77/10 during the done cycle → accepted; 8 edges later quotient=7, remainder=7.
- Start 100/7, drop rst_n at iteration 4 (asynchronously, mid-cycle) → outputs 0 immediately, no done. Release reset, then start 100/7 → correct 14/2.
- Random sweep of 1000 operand pairs, including divisor=0 and divisor>dividend → quotient*divisor+remainder==dividend, remainder<divisor, done exactly once per accepted start.

Source files
------------

// File: rtl/seq_div_ctrl.sv
// Iterative restoring divider: one (WIDTH+1)-bit subtract/restore row reused
// over WIDTH cycles, behind a start/done handshake.
module seq_div_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
    // done is high for exactly the one cycle spent in DONE, and quotient,
    // remainder and div_by_zero are valid from that cycle until the next
    // accepted start.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   row_a;
    logic [WIDTH:0]   row_b;
    logic [WIDTH:0]   row_diff;
    logic [WIDTH:0]   row_out;
    logic             ctrl;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             row_msb_unused;

    // Ripple of full-subtractor cells; the last borrow-out drives the row's
    // restore mux.
    always_comb begin
        logic borrow;
        row_a    = {r, q[WIDTH-1]};
        row_b    = {1'b0, dvs};
        row_diff = '0;
        borrow   = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            row_diff[i] = row_a[i] ^ row_b[i] ^ borrow;
            borrow      = (~row_a[i] & row_b[i]) | (~(row_a[i] ^ row_b[i]) & borrow);
        end
        ctrl    = borrow;
        row_out = ctrl ? row_a : row_diff;
    end

    // The row's top bit is always zero because the partial remainder stays below the divisor.
    assign row_msb_unused = row_out[WIDTH];
    assign r_next         = row_out[WIDTH-1:0];
    assign q_next         = {q[WIDTH-2:0], ~ctrl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvs         <= divisor;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            r     <= '0;
                            q     <= dividend;
                            count <= '0;
                        end
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                CALC: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Bench for seq_div_ctrl: cycle-level behavioural model built on / and %,
// a per-cycle compare process, directed scenarios and a random sweep.
module tb_seq_div_ctrl;

    localparam int W = 8;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_bad = 0;
    int done_seen = 0;

    seq_div_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
        .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: operation result from / and %, timing as a countdown.
    logic         m_busy = 0, m_done = 0, m_dz = 0;
    logic [W-1:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    int           m_left = 0;
    int           m_comp = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_dz <= 0;
            m_q <= 0; m_r <= 0; m_left <= 0;
        end else if (!m_busy && start) begin
            if (divisor == 0) begin
                m_busy <= 0; m_done <= 1; m_dz <= 1;
                m_q <= ALL1; m_r <= dividend;
                m_comp <= m_comp + 1;
            end else begin
                m_busy <= 1; m_done <= 0; m_dz <= 0;
                m_left <= W;
                p_q <= dividend / divisor;
                p_r <= dividend % divisor;
            end
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 0; m_done <= 1;
                m_q <= p_q; m_r <= p_r;
                m_comp <= m_comp + 1;
            end
        end else begin
            m_done <= 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", div_by_zero, m_dz);
        if (done === 1'b1) done_seen++;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom_range(0, 255));
        divisor = W'($urandom_range(0, 255));
    endtask

    // lat = rising edges from the accepting edge up to the one that raised done.
    task automatic wait_done(input bit noise, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            if (noise && busy === 1'b1) begin
                start = 1'(($urandom_range(0, 1)));
                dividend = W'($urandom_range(0, 255));
                divisor = W'($urandom_range(0, 255));
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout: got no done, expected done within 40 edges");
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name, input bit noise);
        int lat;
        issue(a, b);
        wait_done(noise, lat);
        chk({name, "_latency"}, lat, (b == 0) ? 1 : W + 1);
        if (b != 0) begin
            chk({name, "_identity"}, quotient * b + remainder, a);
            chk({name, "_rem_lt_div"}, (remainder < b), 1);
        end else begin
            chk({name, "_dz_rem"}, remainder, a);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] a, b;
        start = 0; dividend = 0; divisor = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_dz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(100, 7, "d100_7", 0);
        chk("d100_7_q", quotient, 14);
        chk("d100_7_r", remainder, 2);
        @(negedge clk);
        run_op(255, 1, "d255_1", 0);
        chk("d255_1_q", quotient, 255);
        chk("d255_1_r", remainder, 0);
        run_op(5, 9, "d5_9", 0);
        chk("d5_9_q", quotient, 0);
        chk("d5_9_r", remainder, 5);
        run_op(255, 255, "d255_255", 0);
        chk("d255_255_q", quotient, 1);
        chk("d255_255_r", remainder, 0);
        @(negedge clk);
        run_op(200, 0, "d200_0", 0);
        chk("d200_0_q", quotient, 255);
        chk("d200_0_dz", div_by_zero, 1);
        @(negedge clk);
        run_op(9, 3, "d9_3", 0);
        chk("d9_3_q", quotient, 3);
        chk("d9_3_dz", div_by_zero, 0);

        // start while busy is ignored; start during done is taken.
        @(negedge clk);
        issue(100, 7);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 50; divisor = 5;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, lat);
        chk("ignore_lat", lat, W - 2);
        chk("ignore_q", quotient, 14);
        chk("ignore_r", remainder, 2);
        run_op(77, 10, "b2b", 0);
        chk("b2b_q", quotient, 7);
        chk("b2b_r", remainder, 7);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        issue(100, 7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(100, 7, "after_abort", 0);
        chk("after_abort_q", quotient, 14);
        chk("after_abort_r", remainder, 2);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0: b = 0;
                1, 2, 3: b = (a == ALL1) ? ALL1 : W'($urandom_range(int'(a) + 1, 255));
                default: b = W'($urandom_range(1, 255));
            endcase
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            run_op(a, b, "rand", 1);
        end

        repeat (3) @(negedge clk);
        chk("done_count", done_seen, m_comp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
